// File: rtl/nzcv_pkg.sv
// Shared constants for the NZCV flag unit: opcodes, ARM condition codes, flag bit indices,
// and the condition evaluator used when NZCV_COND_EVAL_EN is defined.
package nzcv_pkg;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpCmp = 4'b1000;
  localparam logic [3:0] OpCmn = 4'b1001;
  localparam logic [3:0] OpTst = 4'b1010;
  localparam logic [3:0] OpNop = 4'b1111;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FlagN];
    z = f[FlagZ];
    c = f[FlagC];
    v = f[FlagV];
    case (cond)
      CondEq:  return z;
      CondNe:  return ~z;
      CondCs:  return c;
      CondCc:  return ~c;
      CondMi:  return n;
      CondPl:  return ~n;
      CondVs:  return v;
      CondVc:  return ~v;
      CondHi:  return c & ~z;
      CondLs:  return ~c | z;
      CondGe:  return n == v;
      CondLt:  return n != v;
      CondGt:  return ~z & (n == v);
      CondLe:  return z | (n != v);
      CondAl:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nzcv_flag_stack.sv
// Shadow flag LIFO for interrupt entry/exit. Entry 0 is always the top, so push/pop are
// plain shifts and no address arithmetic is needed.
module nzcv_flag_stack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [3:0]                   din,
  output logic [3:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      mem_d [DEPTH];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_en, rd_en;

  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign wr_en = push & ~pop & ~full;
  assign rd_en = pop & ~push & ~empty;
  assign dout  = mem_q[0];
  assign cnt   = cnt_q;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (wr_en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
      cnt_d = cnt_q + CntW'(1);
    end else if (rd_en) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Contents are don't-care after reset; only the occupancy is reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nzcv_flag_unit.sv
// NZCV flag register with shadow stack and condition evaluation.
// Optional: define NZCV_COND_EVAL_EN to enable cond decode; otherwise cond_pass is tied to 1.
module nzcv_flag_unit
  import nzcv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [3:0]                 opcode,
  input  logic                       s_bit,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [WIDTH-1:0]           result,
  input  logic                       push,
  input  logic                       pop,
  input  logic [3:0]                 cond,
  output logic [3:0]                 flags,
  output logic                       cond_pass,
  output logic [$clog2(DEPTH+1)-1:0] stk_cnt,
  output logic                       stk_err
);

  logic [3:0] flags_q, flags_d;
  logic       err_q, err_d;
  logic [3:0] upd_flags;
  logic       upd, pop_ok;
  logic [3:0] stk_dout;
  logic       stk_full, stk_empty;
  logic       msb_a, msb_b, msb_r;

  nzcv_flag_stack #(
    .DEPTH(DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (flags_q),
    .dout (stk_dout),
    .cnt  (stk_cnt),
    .full (stk_full),
    .empty(stk_empty)
  );

  assign msb_a = in_a[WIDTH-1];
  assign msb_b = in_b[WIDTH-1];
  assign msb_r = result[WIDTH-1];

  always_comb begin
    upd_flags        = flags_q;
    upd_flags[FlagN] = msb_r;
    upd_flags[FlagZ] = (result == '0);
    case (opcode)
      OpAdd, OpCmn: begin
        upd_flags[FlagC] = (result < in_a);
        upd_flags[FlagV] = (msb_a == msb_b) & (msb_r != msb_a);
      end
      OpSub, OpCmp: begin
        upd_flags[FlagC] = (in_a >= in_b);
        upd_flags[FlagV] = (msb_a != msb_b) & (msb_r != msb_a);
      end
      default: ;  // TST and logical ops keep C/V
    endcase
  end

  always_comb begin
    upd = valid & ((s_bit & (opcode != OpNop)) |
                   (opcode == OpCmp) | (opcode == OpCmn) | (opcode == OpTst));
    pop_ok = pop & ~push & ~stk_empty;
    // A successful pop overrides any same-cycle update.
    if (pop_ok)   flags_d = stk_dout;
    else if (upd) flags_d = upd_flags;
    else          flags_d = flags_q;
    err_d = err_q | (push & ~pop & stk_full) | (pop & ~push & stk_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign flags   = flags_q;
  assign stk_err = err_q;

`ifdef NZCV_COND_EVAL_EN
  assign cond_pass = cond_eval(cond, flags_q);
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign cond_pass   = 1'b1;
`endif

endmodule
